// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and default widths for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W     = 12;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_MAX_STREAK = 4;
    localparam int DEF_TIMEOUT    = 15;
    localparam int STREAK_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } arb_state_t;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_priority.sv
// Grant select for the memory port: data wins unless fetch has been passed over
// MAX_STREAK times in a row, tracked by a saturating streak counter.
module mem_arb_priority
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_STREAK = DEF_MAX_STREAK
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_req_f,
    input  logic   i_req_d,
    input  logic   i_grant_en,
    output logic   o_grant,
    output owner_t o_owner
);

    localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] r_streak;
    logic                w_force_f;

    assign w_force_f = i_req_f && (r_streak == MAX_S);
    assign o_grant   = i_req_f || i_req_d;
    assign o_owner   = (i_req_d && !w_force_f) ? OWN_D : OWN_F;

    // Only data grants that bypass a waiting fetch count toward the streak.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak <= '0;
        end else if (i_grant_en && o_grant) begin
            if (o_owner == OWN_D && i_req_f)
                r_streak <= (r_streak == MAX_S) ? r_streak : r_streak + 4'd1;
            else
                r_streak <= '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and data paths (IDLE/BUSY/RESP).
// Optional BUSY watchdog with err output: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MAX_STREAK = DEF_MAX_STREAK,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_f,
    input  logic [ADDR_W-1:0] addr_f,
    input  logic              req_d,
    input  logic              we_d,
    input  logic [ADDR_W-1:0] addr_d,
    input  logic [DATA_W-1:0] wdata_d,
    output logic              ack_f,
    output logic              ack_d,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
`ifdef MEM_ARB_TIMEOUT_EN
    , output logic            err
`endif
);

    if (MAX_STREAK < 1 || MAX_STREAK > 15 || TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_param
        $error("mem_port_arbiter: MAX_STREAK and TIMEOUT must be in 1..15");
    end

    arb_state_t        r_state, w_state_nxt;
    owner_t            r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_idle, w_grant;
    owner_t            w_owner;

    assign w_idle = (r_state == ST_IDLE);

    mem_arb_priority #(.MAX_STREAK(MAX_STREAK)) u_prio (
        .clk        (clk),
        .rst        (rst),
        .i_req_f    (req_f),
        .i_req_d    (req_d),
        .i_grant_en (w_idle),
        .o_grant    (w_grant),
        .o_owner    (w_owner)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

    logic [3:0] r_tcnt;
    logic       r_err;
    logic       w_timeout;

    assign w_timeout = (r_state == ST_BUSY) && !mem_ready && (r_tcnt == TO_LAST);

    // Counts BUSY cycles; r_err is only ever high during the RESP that follows an abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            r_tcnt <= (r_state == ST_BUSY) ? r_tcnt + 4'd1 : 4'd0;
            r_err  <= w_timeout;
        end
    end

    assign err = r_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_grant) w_state_nxt = ST_BUSY;
            ST_BUSY: begin
                if (mem_ready) w_state_nxt = ST_RESP;
`ifdef MEM_ARB_TIMEOUT_EN
                else if (w_timeout) w_state_nxt = ST_RESP;
`endif
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_F;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_idle && w_grant) begin
                r_owner <= w_owner;
                r_we    <= (w_owner == OWN_D) && we_d;
                r_addr  <= (w_owner == OWN_D) ? addr_d : addr_f;
                if (w_owner == OWN_D) r_wdata <= wdata_d;
            end
            if (r_state == ST_BUSY && mem_ready && !r_we)
                r_rdata <= mem_rdata;
        end
    end

    assign ack_f     = (r_state == ST_RESP) && (r_owner == OWN_F);
    assign ack_d     = (r_state == ST_RESP) && (r_owner == OWN_D);
    assign mem_en    = (r_state == ST_BUSY);
    assign mem_we    = (r_state == ST_BUSY) && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rdata     = r_rdata;
    assign busy      = !w_idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: per-requester expectation queues,
// directed cycle checks for latency, contention, starvation, wait states and reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_f, req_d, we_d;
    logic [11:0] addr_f, addr_d;
    logic [15:0] wdata_d;
    logic        ack_f, ack_d;
    logic [15:0] rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_ready = 1'b0;
    logic        busy;
`ifdef MEM_ARB_TIMEOUT_EN
    logic        err;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .req_f(req_f), .addr_f(addr_f),
        .req_d(req_d), .we_d(we_d), .addr_d(addr_d), .wdata_d(wdata_d),
        .ack_f(ack_f), .ack_d(ack_d), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
`ifdef MEM_ARB_TIMEOUT_EN
        , .err(err)
`endif
    );

    typedef struct {
        logic        keep;  // rdata must stay at the last read value
        logic [15:0] rd;
        logic        err;
    } exp_t;

    exp_t        q_f[$];
    exp_t        q_d[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          ws = 0;
    int          bcnt = 0;
    logic [15:0] last_rd = 16'h0;

    function automatic logic [15:0] rdfun(input logic [11:0] a);
        if (a == 12'h010) return 16'hBEEF;
        return {a[3:0], a} ^ 16'h5A5A;
    endfunction

    assign mem_rdata = rdfun(mem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: ws wait-state cycles in BUSY before mem_ready.
    always @(negedge clk) begin
        if (mem_en) begin
            mem_ready <= (bcnt >= ws);
            bcnt      <= bcnt + 1;
        end else begin
            mem_ready <= (ws == 0);
            bcnt      <= 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ack_f && ack_d) check("ack_both", 1, 0);
        if (ack_d) begin
            if (q_d.size() == 0) check("ack_d_unexpected", 1, 0);
            else begin
                e = q_d.pop_front();
                check("rdata_d", rdata, e.keep ? last_rd : e.rd);
                if (!e.keep) last_rd = e.rd;
`ifdef MEM_ARB_TIMEOUT_EN
                check("err_d", err, e.err);
`endif
            end
        end
        if (ack_f) begin
            if (q_f.size() == 0) check("ack_f_unexpected", 1, 0);
            else begin
                e = q_f.pop_front();
                check("rdata_f", rdata, e.rd);
                last_rd = e.rd;
            end
        end
    end

    task automatic issue_d(input logic we, input logic [11:0] a, input logic [15:0] wd);
        exp_t e;
        e.keep = we; e.rd = rdfun(a); e.err = 1'b0;
        q_d.push_back(e);
        req_d = 1'b1; we_d = we; addr_d = a; wdata_d = wd;
    endtask

    task automatic issue_f(input logic [11:0] a);
        exp_t e;
        e.keep = 1'b0; e.rd = rdfun(a); e.err = 1'b0;
        q_f.push_back(e);
        req_f = 1'b1; addr_f = a;
    endtask

    task automatic wait_ack_d(output int c);
        bit got = 0;
        c = -1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (ack_d) begin got = 1; c = cyc; end
        end
        if (!got) check("ack_d_timeout", 0, 1);
        @(posedge clk); #1;
        req_d = 1'b0;
    endtask

    task automatic wait_ack_f(output int c);
        bit got = 0;
        c = -1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (ack_f) begin got = 1; c = cyc; end
        end
        if (!got) check("ack_f_timeout", 0, 1);
        @(posedge clk); #1;
        req_f = 1'b0;
    endtask

    int c0, cd, cf, nd, nb;
    bit fdone, got;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_f = 1'b0; addr_f = '0; req_d = 1'b0; we_d = 1'b0;
        addr_d = '0; wdata_d = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack_f", ack_f, 0);     check("rst_ack_d", ack_d, 0);
        check("rst_mem_en", mem_en, 0);   check("rst_mem_we", mem_we, 0);
        check("rst_busy", busy, 0);       check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0); check("rst_rdata", rdata, 0);
        @(posedge clk); #1 rst = 1'b0;

        // single read, no contention
        @(posedge clk); #1;
        c0 = cyc;
        issue_d(1'b0, 12'h010, 16'h0);
        @(negedge clk); check("t1_c0_mem_en", mem_en, 0);
        @(negedge clk);
        check("t1_c1_mem_en", mem_en, 1); check("t1_c1_addr", mem_addr, 12'h010);
        check("t1_c1_we", mem_we, 0);     check("t1_c1_busy", busy, 1);
        @(negedge clk);
        check("t1_c2_ack_d", ack_d, 1);   check("t1_c2_mem_en", mem_en, 0);
        check("t1_c2_rdata", rdata, 16'hBEEF);
        @(posedge clk); #1 req_d = 1'b0;
        @(negedge clk); check("t1_c3_busy", busy, 0);

        // simultaneous requests: data first, fetch next
        @(posedge clk); #1;
        c0 = cyc;
        fork
            begin issue_f(12'h0A0); wait_ack_f(cf); end
            begin issue_d(1'b0, 12'h0B0, 16'h0); wait_ack_d(cd); end
        join
        check("t2_ack_d_cycle", cd - c0, 2);
        check("t2_ack_f_cycle", cf - c0, 5);

        // starvation, twice: the streak must have cleared in between
        for (int r = 0; r < 2; r++) begin
            nd = 0; fdone = 0;
            fork
                begin issue_f(12'h100 + 12'(r)); wait_ack_f(cf); fdone = 1; end
                begin
                    for (int i = 0; i < 6; i++) begin
                        issue_d(1'b0, 12'h200 + 12'(i) + 12'(r * 8), 16'h0);
                        wait_ack_d(cd);
                        if (!fdone) nd++;
                    end
                end
            join
            check("t3_data_before_fetch", nd, 4);
        end

        // write with three wait states
        ws = 3;
        c0 = cyc;
        issue_d(1'b1, 12'h020, 16'h1234);
        nb = 0; got = 0; cd = -1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (mem_en) begin
                nb++;
                check("t4_mem_we", mem_we, 1);
                check("t4_mem_wdata", mem_wdata, 16'h1234);
                check("t4_mem_addr", mem_addr, 12'h020);
            end
            if (ack_d) begin got = 1; cd = cyc; end
        end
        check("t4_ack_seen", got, 1);
        check("t4_busy_cycles", nb, 4);
        check("t4_ack_cycle", cd - c0, 5);
        @(posedge clk); #1 req_d = 1'b0; ws = 0;

        // reset during the second BUSY cycle, then regrant
        @(posedge clk); #1;
        ws = 255;
        c0 = cyc;
        req_d = 1'b1; we_d = 1'b0; addr_d = 12'h030;
        @(negedge clk);
        @(negedge clk); check("t5_c1_mem_en", mem_en, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk); check("t5_c2_mem_en", mem_en, 1);
        @(posedge clk); #1 rst = 1'b0; ws = 0;
        @(negedge clk);
        check("t5_c3_mem_en", mem_en, 0); check("t5_c3_busy", busy, 0);
        check("t5_c3_ack_d", ack_d, 0);
        begin
            exp_t e;
            e.keep = 1'b0; e.rd = rdfun(12'h030); e.err = 1'b0;
            q_d.push_back(e);
        end
        wait_ack_d(cd);
        check("t5_regrant_ack_cycle", cd - c0, 5);

`ifdef MEM_ARB_TIMEOUT_EN
        // watchdog abort: rdata untouched, err with the ack
        ws = 255;
        c0 = cyc;
        begin
            exp_t e;
            e.keep = 1'b1; e.rd = 16'h0; e.err = 1'b1;
            q_d.push_back(e);
        end
        req_d = 1'b1; we_d = 1'b0; addr_d = 12'h040;
        wait_ack_d(cd);
        check("t6_timeout_ack_cycle", cd - c0, 16);
        ws = 0;
        @(negedge clk); check("t6_err_cleared", err, 0);
`endif

        repeat (3) @(posedge clk);
        check("q_f_drained", q_f.size(), 0);
        check("q_d_drained", q_d.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
